// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core with load-use hazard detection and flush.
// Optional hazard counters are built when ID_EX_HAZARD_CNT_EN is defined.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteD,
    input  logic        MemReadD,
    input  logic        MemWriteD,
    input  logic        ALUSrcD,
    input  logic [2:0]  ALUControlD,
    input  logic        BranchD,
    input  logic        JumpD,
    input  logic        UseRs1D,
    input  logic        UseRs2D,
    input  logic [4:0]  rs1D,
    input  logic [4:0]  rs2D,
    input  logic [4:0]  rdD,
    input  logic [31:0] ImmOpD,
    input  logic [31:0] PCD,
    input  logic        ValidD,
    input  logic        FlushE,
    output logic        RegWriteE,
    output logic        MemReadE,
    output logic        MemWriteE,
    output logic        ALUSrcE,
    output logic        BranchE,
    output logic        JumpE,
    output logic        ValidE,
    output logic [2:0]  ALUControlE,
    output logic [4:0]  rs1E,
    output logic [4:0]  rs2E,
    output logic [4:0]  rdE,
    output logic [31:0] ImmOpE,
    output logic [31:0] PCE,
    output logic        StallFD,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        logic        branch;
        logic        jump;
        logic        valid;
        logic [2:0]  alu_ctrl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
    } ex_fields_t;

    ex_fields_t ex_q;
    ex_fields_t ex_d;
    ex_fields_t d_fields_s;
    logic       load_use_s;

    assign d_fields_s = '{reg_write: RegWriteD, mem_read: MemReadD, mem_write: MemWriteD,
                          alu_src: ALUSrcD, branch: BranchD, jump: JumpD, valid: ValidD,
                          alu_ctrl: ALUControlD, rs1: rs1D, rs2: rs2D, rd: rdD,
                          imm: ImmOpD, pc: PCD};

    // Hazard detection uses only registered E state and D inputs, so no loop forms.
    always_comb begin
        load_use_s = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                     ((UseRs1D & (rs1D == ex_q.rd)) | (UseRs2D & (rs2D == ex_q.rd)));
        StallFD    = load_use_s & ~FlushE;
        if (FlushE || load_use_s) begin
            ex_d = '0;
        end else begin
            ex_d = d_fields_s;
        end
    end

    // Pipeline register; reset loads a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign RegWriteE   = ex_q.reg_write;
    assign MemReadE    = ex_q.mem_read;
    assign MemWriteE   = ex_q.mem_write;
    assign ALUSrcE     = ex_q.alu_src;
    assign BranchE     = ex_q.branch;
    assign JumpE       = ex_q.jump;
    assign ValidE      = ex_q.valid;
    assign ALUControlE = ex_q.alu_ctrl;
    assign rs1E        = ex_q.rs1;
    assign rs2E        = ex_q.rs2;
    assign rdE         = ex_q.rd;
    assign ImmOpE      = ex_q.imm;
    assign PCE         = ex_q.pc;

`ifdef ID_EX_HAZARD_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;
    logic [15:0] flush_cnt_q;
    logic [15:0] flush_cnt_d;

    // Saturating event counters; a flush suppresses the stall count.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallFD && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (FlushE && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    assign StallCount = 16'd0;
    assign FlushCount = 16'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a behavioural model pushes expected state, a negedge monitor checks.
module tb_id_ex_stage;

`ifdef ID_EX_HAZARD_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct packed {
        logic        rw, mr, mw, as, br, jp, vl;
        logic [2:0]  alu;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm, pc;
    } e_t;

    typedef struct packed {
        e_t          e;
        logic        stall;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // D-side stimulus
    e_t   d;
    logic u1, u2, rst, flush;

    // DUT outputs
    logic        RegWriteE, MemReadE, MemWriteE, ALUSrcE, BranchE, JumpE, ValidE, StallFD;
    logic [2:0]  ALUControlE;
    logic [4:0]  rs1E, rs2E, rdE;
    logic [31:0] ImmOpE, PCE;
    logic [15:0] StallCount, FlushCount;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .RegWriteD(d.rw), .MemReadD(d.mr), .MemWriteD(d.mw), .ALUSrcD(d.as),
        .ALUControlD(d.alu), .BranchD(d.br), .JumpD(d.jp),
        .UseRs1D(u1), .UseRs2D(u2), .rs1D(d.rs1), .rs2D(d.rs2), .rdD(d.rd),
        .ImmOpD(d.imm), .PCD(d.pc), .ValidD(d.vl), .FlushE(flush),
        .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE), .ValidE(ValidE),
        .ALUControlE(ALUControlE), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .ImmOpE(ImmOpE), .PCE(PCE), .StallFD(StallFD),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    e_t          m_e;
    logic [15:0] m_sc, m_fc;
    exp_t        sb_q[$];

    function automatic logic model_load_use();
        return m_e.vl && m_e.mr && (m_e.rd != 5'd0) &&
               ((u1 && d.rs1 == m_e.rd) || (u2 && d.rs2 == m_e.rd));
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Issue one cycle: push expectation for the current cycle, then advance the model over the edge.
    task automatic apply();
        exp_t x;
        logic lu;
        lu      = model_load_use();
        x.e     = m_e;
        x.stall = lu && !flush;
        x.sc    = m_sc;
        x.fc    = m_fc;
        sb_q.push_back(x);
        @(posedge clk);
        if (rst || flush || lu) m_e = '0;
        else                    m_e = d;
        if (CNT_ON) begin
            if (rst) begin
                m_sc = 16'd0;
                m_fc = 16'd0;
            end else begin
                if (lu && !flush) m_sc = sat_inc(m_sc);
                if (flush)        m_fc = sat_inc(m_fc);
            end
        end
        #1;
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    always @(negedge clk) begin
        exp_t x;
        e_t   a;
        if (sb_q.size() != 0) begin
            x = sb_q.pop_front();
            a = '{rw: RegWriteE, mr: MemReadE, mw: MemWriteE, as: ALUSrcE, br: BranchE,
                  jp: JumpE, vl: ValidE, alu: ALUControlE, rs1: rs1E, rs2: rs2E, rd: rdE,
                  imm: ImmOpE, pc: PCE};
            total++;
            if (a !== x.e) begin
                bad++;
                $display("FAIL e_fields got=%h want=%h", a, x.e);
            end
            total++;
            if (StallFD !== x.stall) begin
                bad++;
                $display("FAIL stall_fd got=%b want=%b", StallFD, x.stall);
            end
            total++;
            if ({StallCount, FlushCount} !== {x.sc, x.fc}) begin
                bad++;
                $display("FAIL counters got=%h/%h want=%h/%h", StallCount, FlushCount, x.sc, x.fc);
            end
        end
    end

    task automatic clear_d();
        d = '0; u1 = 1'b0; u2 = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    task automatic rand_d();
        d  = e_t'({$urandom, $urandom, $urandom});
        d.rs1 = 5'($urandom_range(0, 3));
        d.rs2 = 5'($urandom_range(0, 3));
        d.rd  = 5'($urandom_range(0, 3));
        d.mr  = ($urandom_range(0, 2) == 0);
        d.vl  = ($urandom_range(0, 7) != 0);
        u1 = $urandom_range(0, 1) == 1;
        u2 = $urandom_range(0, 1) == 1;
    endtask

    task automatic do_reset();
        rand_d();
        rst = 1'b1; flush = 1'b0;
        apply();
        rand_d();
        apply();
        rst = 1'b0;
    endtask

    initial begin
        m_e = '0; m_sc = 16'd0; m_fc = 16'd0;
        clear_d();
        rand_d();
        rst = 1'b1;
        @(posedge clk); #1;   // first reset edge: outputs are unknown before it
        do_reset();
        check("reset_valid", {31'd0, ValidE}, 32'd0);
        check("reset_pc", PCE, 32'd0);
        check("reset_stall", {31'd0, StallFD}, 32'd0);

        // Pass-through
        clear_d();
        d.rd = 5'd5; d.imm = 32'h0000_0010; d.pc = 32'h40; d.rw = 1'b1; d.vl = 1'b1;
        apply();
        check("pass_rd", {27'd0, rdE}, 32'd5);
        check("pass_imm", ImmOpE, 32'h10);
        check("pass_pc", PCE, 32'h40);
        check("pass_rw_valid", {30'd0, RegWriteE, ValidE}, 32'd3);

        // Load-use
        do_reset();
        clear_d();
        d.mr = 1'b1; d.rd = 5'd7; d.vl = 1'b1; d.rw = 1'b1;
        apply();
        clear_d();
        u2 = 1'b1; d.rs2 = 5'd7; d.rd = 5'd9; d.pc = 32'h88; d.vl = 1'b1;
        #1 check("lu_stall", {31'd0, StallFD}, 32'd1);
        apply();
        check("lu_bubble", {31'd0, ValidE}, 32'd0);
        apply();
        check("lu_capture_pc", PCE, 32'h88);
        check("lu_stallcnt", {16'd0, StallCount}, CNT_ON ? 32'd1 : 32'd0);

        // x0 destination and unused operand
        clear_d();
        d.mr = 1'b1; d.rd = 5'd0; d.vl = 1'b1;
        apply();
        clear_d();
        u1 = 1'b1; d.rs1 = 5'd0;
        #1 check("x0_stall", {31'd0, StallFD}, 32'd0);
        d.mr = 1'b1; d.rd = 5'd3; d.vl = 1'b1; u1 = 1'b0;
        apply();
        clear_d();
        d.rs1 = 5'd3;
        #1 check("unused_stall", {31'd0, StallFD}, 32'd0);
        apply();

        // Flush overrides load-use
        do_reset();
        clear_d();
        d.mr = 1'b1; d.rd = 5'd7; d.vl = 1'b1;
        apply();
        clear_d();
        u1 = 1'b1; d.rs1 = 5'd7; d.vl = 1'b1; flush = 1'b1;
        #1 check("flush_stall", {31'd0, StallFD}, 32'd0);
        apply();
        check("flush_bubble", {31'd0, ValidE}, 32'd0);
        check("flush_cnts", {StallCount, FlushCount}, CNT_ON ? 32'h0000_0001 : 32'd0);

        // Mid-stall reset
        clear_d();
        d.mr = 1'b1; d.rd = 5'd2; d.vl = 1'b1;
        apply();
        clear_d();
        u1 = 1'b1; d.rs1 = 5'd2; d.vl = 1'b1; rst = 1'b1;
        apply();
        check("rst_stall_drop", {30'd0, ValidE, StallFD}, 32'd0);

        // Randomized traffic; a stalled instruction is usually re-presented
        for (int i = 0; i < 3000; i++) begin
            if (!(sb_q.size() == 0 && model_load_use() && $urandom_range(0, 3) != 0)) begin
                rand_d();
                flush = ($urandom_range(0, 7) == 0);
            end else begin
                flush = 1'b0;
            end
            rst = ($urandom_range(0, 99) == 0);
            apply();
        end

        // Saturation: 65,536 consecutive flushes
        do_reset();
        clear_d();
        flush = 1'b1;
        for (int i = 0; i < (CNT_ON ? 65536 : 300); i++) begin
            rand_d();
            apply();
        end
        check("flush_sat", {16'd0, FlushCount}, CNT_ON ? 32'h0000_FFFF : 32'd0);
        flush = 1'b0;
        apply();

        @(negedge clk);
        @(posedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
